// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer-width constants and Gray/binary helpers for the dual-clock FIFO
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int PTR_W              = DEFAULT_ADDR_WIDTH + 1;

    // Helpers run at a fixed wide width; callers zero-extend and truncate to their own pointer width.
    localparam int FN_W = 32;

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// rtl/fifo_ptr_sync.sv - multi-flop synchroniser for a Gray pointer crossing clock domains
module fifo_ptr_sync #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ptr,
    output logic [WIDTH-1:0] ptr_sync
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign ptr_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/async_fifo_read_ctrl.sv
// rtl/async_fifo_read_ctrl.sv - read-domain pointer, empty/almost-empty flags and fill level
module async_fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 2
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH:0]   wr_gray_ptr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   gray_read_ptr,
    output logic                  rd_fire,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] wr_gray_s;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] level_next;

    fifo_ptr_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk      (rd_clk),
        .rst      (reset),
        .ptr      (wr_gray_ptr),
        .ptr_sync (wr_gray_s)
    );

    // Flags are computed from the post-read pointer so a read that drains the FIFO sees empty next edge.
    always_comb begin
        rd_fire      = read_en & ~empty;
        rd_bin_next  = rd_bin + PW'(rd_fire);
        rd_gray_next = PW'(bin2gray(FN_W'(rd_bin_next)));
        wr_bin_s     = PW'(gray2bin(FN_W'(wr_gray_s)));
        level_next   = wr_bin_s - rd_bin_next;
    end

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            rd_bin        <= '0;
            gray_read_ptr <= '0;
            empty         <= 1'b1;
            almost_empty  <= 1'b1;
            rd_level      <= '0;
            underflow     <= 1'b0;
        end else begin
            rd_bin        <= rd_bin_next;
            gray_read_ptr <= rd_gray_next;
            empty         <= (rd_gray_next == wr_gray_s);
            almost_empty  <= (int'(level_next) <= AE_THRESH);
            rd_level      <= level_next;
            underflow     <= read_en & empty;
        end
    end

    assign read_addr = rd_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
// tb/tb_async_fifo_read_ctrl.sv - directed vector and sequence bench for async_fifo_read_ctrl
module tb_async_fifo_read_ctrl;

    logic       rd_clk = 1'b0;
    logic       reset  = 1'b1;
    logic       read_en = 1'b0;
    logic [4:0] wr_gray_ptr = 5'd0;
    logic [3:0] read_addr;
    logic [4:0] gray_read_ptr;
    logic       rd_fire;
    logic       empty;
    logic       almost_empty;
    logic [4:0] rd_level;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    async_fifo_read_ctrl #(
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .AE_THRESH   (2)
    ) dut (
        .rd_clk        (rd_clk),
        .reset         (reset),
        .read_en       (read_en),
        .wr_gray_ptr   (wr_gray_ptr),
        .read_addr     (read_addr),
        .gray_read_ptr (gray_read_ptr),
        .rd_fire       (rd_fire),
        .empty         (empty),
        .almost_empty  (almost_empty),
        .rd_level      (rd_level),
        .underflow     (underflow)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge rd_clk);
        #1;
    endtask

    // Per-cycle Gray consistency against the internal binary pointer, plus single-bit stepping.
    logic [4:0] prev_gray = 5'd0;
    always @(negedge rd_clk) begin
        if (reset) begin
            prev_gray = 5'd0;
        end else begin
            checks++;
            assert (gray_read_ptr == g(dut.rd_bin) && $countones(gray_read_ptr ^ prev_gray) <= 1)
            else begin
                errors++;
                $display("FAIL gray_track: got %0d expected %0d prev %0d", gray_read_ptr, g(dut.rd_bin), prev_gray);
            end
            prev_gray = gray_read_ptr;
        end
    end

    typedef struct {
        logic       re;
        logic [4:0] wr;
        logic       fire;
        logic [3:0] addr;
        logic       emp;
        logic [4:0] lvl;
        logic       ae;
        logic       uf;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;
        int fires;
        int w;
        logic [31:0] seen;
        logic wrapped;
        logic [3:0] last_addr;

        // re, wr_gray, fire, addr | after edge: empty, level, almost_empty, underflow
        vecs[0]  = '{1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd2, 1'b0, 4'd0, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 5'd2, 1'b0, 4'd0, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 5'd2, 1'b0, 4'd0, 1'b0, 5'd3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd2, 1'b1, 4'd0, 1'b0, 5'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 5'd2, 1'b1, 4'd1, 1'b0, 5'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd2, 1'b1, 4'd2, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd2, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 5'd7, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd7, 1'b0, 4'd3, 1'b1, 5'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 5'd7, 1'b0, 4'd3, 1'b0, 5'd2, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 5'd7, 1'b1, 4'd3, 1'b0, 5'd1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 5'd7, 1'b0, 4'd4, 1'b0, 5'd1, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_level", rd_level, 0);
        chk("rst_gray", gray_read_ptr, 0);
        chk("rst_addr", read_addr, 0);
        chk("rst_uf", underflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            read_en     = vecs[i].re;
            wr_gray_ptr = vecs[i].wr;
            #1;
            chk($sformatf("v%0d_fire", i), rd_fire, vecs[i].fire);
            chk($sformatf("v%0d_addr", i), read_addr, vecs[i].addr);
            tick();
            chk($sformatf("v%0d_empty", i), empty, vecs[i].emp);
            chk($sformatf("v%0d_level", i), rd_level, vecs[i].lvl);
            chk($sformatf("v%0d_ae", i), almost_empty, vecs[i].ae);
            chk($sformatf("v%0d_uf", i), underflow, vecs[i].uf);
        end

        // Asynchronous reset mid-stream with a pending read
        read_en = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ae", almost_empty, 1);
        chk("mid_rst_level", rd_level, 0);
        chk("mid_rst_gray", gray_read_ptr, 0);
        chk("mid_rst_addr", read_addr, 0);
        chk("mid_rst_fire", rd_fire, 0);
        read_en     = 1'b0;
        wr_gray_ptr = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Drain five entries
        wr_gray_ptr = g(5'd5);
        tick();
        tick();
        chk("drain_pre_empty", empty, 1);
        tick();
        chk("drain_empty_fall", empty, 0);
        chk("drain_level5", rd_level, 5);
        read_en = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (rd_fire) begin
                chk($sformatf("drain_addr%0d", n), read_addr, n);
                n++;
            end
            tick();
        end
        chk("drain_fires", n, 5);
        chk("drain_empty", empty, 1);
        chk("drain_level0", rd_level, 0);
        chk("drain_addr_hold", read_addr, 5);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_uf%0d", i), underflow, 1);
            chk($sformatf("drain_ptr%0d", i), read_addr, 5);
            tick();
        end

        // Wrap: 40 entries through depth 16
        read_en = 1'b0;
        reset   = 1'b1;
        wr_gray_ptr = 5'd0;
        tick();
        reset = 1'b0;
        tick();
        fires   = 0;
        w       = 0;
        seen    = 32'd1;
        wrapped = 1'b0;
        last_addr = 4'd0;
        for (int cyc = 0; cyc < 3000 && fires < 40; cyc++) begin
            read_en = ($urandom_range(0, 3) != 0);
            #1;
            if (rd_fire) begin
                chk("wrap_addr", read_addr, fires % 16);
                if (fires > 0 && last_addr == 4'd15 && read_addr == 4'd0) wrapped = 1'b1;
                last_addr = read_addr;
                fires++;
            end
            if (rd_level > 5'd16) chk("wrap_level_max", rd_level, 16);
            if (w < 40 && (w - fires) < 16) w++;
            wr_gray_ptr = g(5'(w));
            tick();
            seen[gray_read_ptr] = 1'b1;
        end
        chk("wrap_fires", fires, 40);
        chk("wrap_all_codes", seen, 32'hFFFF_FFFF);
        chk("wrap_addr_15_to_0", wrapped, 1);
        read_en = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
